// File: rtl/cpu_pkg.sv
// Shared encodings for the comparator, the instruction decoder and the
// compare/branch controller: request opcodes, branch conditions and the bit
// positions of the comparator flags.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_CMP   = 2'd0,  // compare a/b, no branch result
    OP_BR    = 2'd1,  // evaluate the flags the comparator already holds
    OP_CMPBR = 2'd2,  // compare a/b, then evaluate the fresh flags
    OP_LOAD  = 2'd3   // load a into the comparator flag register
  } op_e;

  typedef enum logic [2:0] {
    COND_EQ     = 3'd0,
    COND_NE     = 3'd1,
    COND_LT     = 3'd2,
    COND_GT     = 3'd3,
    COND_LE     = 3'd4,
    COND_GE     = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  localparam int FLAG_EQ_BIT = 0;  // bus1 == bus2
  localparam int FLAG_NE_BIT = 1;  // bus1 != bus2
  localparam int FLAG_LT_BIT = 2;  // bus1 <  bus2
  localparam int FLAG_GT_BIT = 3;  // bus1 >  bus2

endpackage

// File: rtl/cmp_branch_ctrl_cond_eval.sv
// cond_eval: purely combinational branch-condition evaluator. Shared with the
// decoder's branch predictor, so it depends only on the low flag nibble.
//   flags  in  4  comparator flags (EQ/NE/LT/GT at the FLAG_* positions)
//   cond   in  3  branch condition (cond_e)
//   taken  out 1  condition holds for these flags
module cond_eval
  import cpu_pkg::*;
#(
  parameter int FLAG_EQ = FLAG_EQ_BIT,
  parameter int FLAG_NE = FLAG_NE_BIT,
  parameter int FLAG_LT = FLAG_LT_BIT,
  parameter int FLAG_GT = FLAG_GT_BIT
) (
  input  logic [3:0] flags,
  input  cond_e      cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_EQ:     taken = flags[FLAG_EQ];
      COND_NE:     taken = flags[FLAG_NE];
      COND_LT:     taken = flags[FLAG_LT];
      COND_GT:     taken = flags[FLAG_GT];
      COND_LE:     taken = flags[FLAG_LT] | flags[FLAG_EQ];
      COND_GE:     taken = flags[FLAG_GT] | flags[FLAG_EQ];
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_branch_ctrl.sv
// cmp_branch_ctrl: sequencer owning the comparator. Serves one decoder request
// at a time (compare, branch evaluate, compare+branch, flag load) and returns
// a taken/not-taken result over a held valid/ready response.
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_op, req_cond, req_a, req_b
//   cmp_compare/cmp_load  comparator strobes, high only in STROBE
//   cmp_bus1/cmp_bus2     comparator operands, held between strobes
//   cmp_flags             comparator flags, valid the cycle after a strobe
//   rsp_valid/rsp_ready   response handshake; rsp_taken result
//   busy                  controller not idle
module cmp_branch_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FLAG_EQ = FLAG_EQ_BIT,
  parameter int FLAG_NE = FLAG_NE_BIT,
  parameter int FLAG_LT = FLAG_LT_BIT,
  parameter int FLAG_GT = FLAG_GT_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_cond,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             cmp_compare,
  output logic             cmp_load,
  output logic [WIDTH-1:0] cmp_bus1,
  output logic [WIDTH-1:0] cmp_bus2,
  input  logic [WIDTH-1:0] cmp_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    EVAL   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e           state, state_nxt;
  op_e              op_q;
  cond_e            cond_q;
  logic [WIDTH-1:0] bus1_q, bus2_q;
  logic             accept;
  logic             taken;

  // Only the low flag nibble carries condition information.
  logic unused_flags;
  assign unused_flags = ^cmp_flags[WIDTH-1:4];

  assign accept   = req_valid && req_ready;
  assign cmp_bus1 = bus1_q;
  assign cmp_bus2 = bus2_q;

  cond_eval #(
    .FLAG_EQ (FLAG_EQ),
    .FLAG_NE (FLAG_NE),
    .FLAG_LT (FLAG_LT),
    .FLAG_GT (FLAG_GT)
  ) u_cond_eval (
    .flags (cmp_flags[3:0]),
    .cond  (cond_q),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (op_e'(req_op) == OP_BR) ? EVAL : STROBE;
      STROBE:  state_nxt = (op_q == OP_CMPBR) ? EVAL : RESP;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    busy        = (state != IDLE);
    rsp_valid   = (state == RESP);
    cmp_compare = (state == STROBE) && (op_q != OP_LOAD);
    cmp_load    = (state == STROBE) && (op_q == OP_LOAD);
  end

  // Request latches. The operand buses double as the a/b latches; a BR leaves
  // them untouched so they keep the operands of the last strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_CMP;
      cond_q <= COND_EQ;
      bus1_q <= '0;
      bus2_q <= '0;
    end else if (accept) begin
      op_q   <= op_e'(req_op);
      cond_q <= cond_e'(req_cond);
      if (op_e'(req_op) != OP_BR) begin
        bus1_q <= req_a;
        bus2_q <= req_b;
      end
    end
  end

  // Result register: captured in EVAL, forced to 0 for CMP/LOAD, held in RESP.
  always_ff @(posedge clk) begin
    if (reset)                                      rsp_taken <= 1'b0;
    else if (state == EVAL)                         rsp_taken <= taken;
    else if ((state == STROBE) && (op_q != OP_CMPBR)) rsp_taken <= 1'b0;
  end

endmodule

// File: tb/tb_cmp_branch_ctrl.sv
// Directed bench for cmp_branch_ctrl with a behavioural comparator attached.
module tb_cmp_branch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_cond;
  logic [15:0] req_a, req_b;
  logic        cmp_compare, cmp_load;
  logic [15:0] cmp_bus1, cmp_bus2;
  logic [15:0] cmp_flags = 16'h0000;
  logic        rsp_valid, rsp_ready, rsp_taken, busy;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmp_branch_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_cond    (req_cond),
    .req_a       (req_a),
    .req_b       (req_b),
    .cmp_compare (cmp_compare),
    .cmp_load    (cmp_load),
    .cmp_bus1    (cmp_bus1),
    .cmp_bus2    (cmp_bus2),
    .cmp_flags   (cmp_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_taken   (rsp_taken),
    .busy        (busy)
  );

  // Comparator: flags update on the edge that samples a strobe.
  always @(posedge clk) begin
    if (cmp_compare)
      cmp_flags <= {12'd0, cmp_bus1 > cmp_bus2, cmp_bus1 < cmp_bus2,
                    cmp_bus1 != cmp_bus2, cmp_bus1 == cmp_bus2};
    else if (cmp_load)
      cmp_flags <= cmp_bus1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, follow it to its response and retire it.
  task automatic run(input string tag, input logic [1:0] op, input logic [2:0] cond,
                     input logic [15:0] a, input logic [15:0] b, input logic exp_taken);
    int lat;
    req_op = op; req_cond = cond; req_a = a; req_b = b; req_valid = 1'b1;
    chk({tag, ".req_ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".cmp_compare"}, cmp_compare, (op == OP_CMP || op == OP_CMPBR));
    chk({tag, ".cmp_load"}, cmp_load, (op == OP_LOAD));
    if (op != OP_BR) begin
      chk({tag, ".bus1"}, cmp_bus1, a);
      chk({tag, ".bus2"}, cmp_bus2, b);
    end
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
      chk({tag, ".strobe_off"}, {cmp_compare, cmp_load}, 0);
    end
    chk({tag, ".latency"}, lat, (op == OP_CMPBR) ? 3 : 2);
    chk({tag, ".rsp_taken"}, rsp_taken, exp_taken);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, rsp_valid, 0);
    chk({tag, ".idle"}, {req_ready, busy}, 2'b10);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_cond = 3'd0;
    req_a = 16'd0; req_b = 16'd0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.ready", req_ready, 1);
    chk("reset.outs", {cmp_compare, cmp_load, rsp_valid, rsp_taken, busy}, 0);
    chk("reset.bus", {cmp_bus1, cmp_bus2}, 0);
    reset = 1'b0;

    // Reset during a CMPBR aborts it.
    req_op = OP_CMPBR; req_cond = COND_EQ; req_a = 16'd9; req_b = 16'd9; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.strobe", cmp_compare, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort.after", {cmp_compare, cmp_load, rsp_valid, req_ready, busy}, 5'b00010);
    @(negedge clk);
    chk("abort.stay_idle", {rsp_valid, busy}, 0);

    run("cmpbr_eq",   OP_CMPBR, COND_EQ,     16'd5, 16'd5, 1'b1);
    run("cmpbr_lt",   OP_CMPBR, COND_LT,     16'd1, 16'd0, 1'b0);
    chk("flags_1010", cmp_flags[3:0], 4'b1010);
    run("br_ge",      OP_BR,    COND_GE,     16'd0, 16'd0, 1'b1);
    run("br_eq",      OP_BR,    COND_EQ,     16'd0, 16'd0, 1'b0);
    run("cmpbr_le",   OP_CMPBR, COND_LE,     16'd0, 16'd1, 1'b1);
    run("cmpbr_nev",  OP_CMPBR, COND_NEVER,  16'd0, 16'd1, 1'b0);
    run("cmpbr_alw",  OP_CMPBR, COND_ALWAYS, 16'd0, 16'd1, 1'b1);
    run("br_ne",      OP_BR,    COND_NE,     16'd0, 16'd0, 1'b1);
    run("load8",      OP_LOAD,  COND_ALWAYS, 16'h0008, 16'h0000, 1'b0);
    run("br_gt",      OP_BR,    COND_GT,     16'd0, 16'd0, 1'b1);
    run("br_ne_ld",   OP_BR,    COND_NE,     16'd0, 16'd0, 1'b0);
    run("cmp",        OP_CMP,   COND_ALWAYS, 16'd2, 16'd9, 1'b0);
    run("br_lt",      OP_BR,    COND_LT,     16'd0, 16'd0, 1'b1);
    run("br_le",      OP_BR,    COND_LE,     16'd0, 16'd0, 1'b1);
    run("cmpbr_ge",   OP_CMPBR, COND_GE,     16'hffff, 16'h0001, 1'b1);

    // Backpressure: response held while a new request waits.
    req_op = OP_CMPBR; req_cond = COND_LT; req_a = 16'd3; req_b = 16'd7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp.rsp_valid", rsp_valid, 1);
    req_op = OP_BR; req_cond = COND_NEVER; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold", {rsp_valid, rsp_taken, req_ready, busy}, 4'b1101);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.released", {rsp_valid, req_ready, busy}, 3'b010);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.accepted", {req_ready, busy}, 2'b01);
    @(negedge clk);
    chk("bp.br_rsp", {rsp_valid, rsp_taken}, 2'b10);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.final_idle", {rsp_valid, req_ready, busy}, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end

endmodule

// File: doc/cmp_branch_ctrl.md
Name: cmp_branch_ctrl

Overview:
Sequencer that owns the 16-bit comparator and serves requests from the instruction decoder over a valid/ready handshake. It performs compares, flag loads and branch-condition evaluation. It drives the comparator's compare/load strobes and operand buses, samples the returned flags, and reports taken/not-taken through a held response handshake. One request is in flight at a time.

Parameters:
WIDTH, 16, operand and flags bus width
FLAG_EQ, 0, flags bit index: operands equal
FLAG_NE, 1, flags bit index: operands not equal
FLAG_LT, 2, flags bit index: bus1 < bus2
FLAG_GT, 3, flags bit index: bus1 > bus2

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_op  in  2  0=CMP, 1=BR (evaluate held flags), 2=CMPBR, 3=LOAD (load flags)
req_cond  in  3  0=EQ,1=NE,2=LT,3=GT,4=LE,5=GE,6=ALWAYS,7=NEVER
req_a  in  WIDTH  operand A; flags value for LOAD
req_b  in  WIDTH  operand B
cmp_compare  out  1  comparator compare strobe
cmp_load  out  1  comparator load strobe
cmp_bus1  out  WIDTH  comparator operand 1
cmp_bus2  out  WIDTH  comparator operand 2
cmp_flags  in  WIDTH  comparator flags, updated on the edge that samples a strobe
rsp_valid  out  1  response present, held until rsp_ready
rsp_ready  in  1  consumer takes response
rsp_taken  out  1  condition result (0 for CMP/LOAD)
busy  out  1  state != IDLE

Behaviour:
- The interface has one clock and synchronous, active-high reset. Ports are named clk and reset.
- Reset values: state=IDLE. req_ready=1 on the first cycle after reset. cmp_compare, cmp_load, rsp_valid, rsp_taken and busy are all 0. cmp_bus1 and cmp_bus2 are 0. Operand and cond latches are 0.
- States: IDLE, STROBE, EVAL, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready. On acceptance, op, cond, a and b are latched.
  - CMP, CMPBR, LOAD go to STROBE.
  - BR goes to EVAL.
- STROBE is exactly one cycle. cmp_bus1/cmp_bus2 = latched a/b.
  - CMP and CMPBR drive cmp_compare=1.
  - LOAD drives cmp_load=1.
  - Next state: CMP/LOAD go to RESP with rsp_taken=0. CMPBR goes to EVAL.
- EVAL is one cycle. It reads cmp_flags, which is now valid.
  - taken = EQ:f[EQ]; NE:f[NE]; LT:f[LT]; GT:f[GT]; LE:f[LT]|f[EQ]; GE:f[GT]|f[EQ]; ALWAYS:1; NEVER:0.
  - rsp_taken is registered. Next state is RESP.
- RESP: rsp_valid=1 and rsp_taken is stable until rsp_ready. In the cycle with rsp_valid&&rsp_ready, the next state is IDLE. No new request is accepted in the same cycle.
- Latency from accept edge to rsp_valid: CMP/LOAD 2 cycles, BR 2 cycles, CMPBR 3 cycles.
- Strobes are high only in STROBE and never both high. Operand buses hold their last values outside STROBE.
- req_ready=0 in every state except IDLE. Requests presented while busy are ignored, and the requester must hold them.
- Reset mid-operation aborts the in-flight request. No strobe or rsp_valid appears on the following cycle. The comparator's own flag state is not the controller's to restore.
- BR with no prior CMP/LOAD evaluates whatever flags the comparator currently holds.

Decomposition:
- Shared package cpu_pkg: op encodings (OP_CMP, OP_BR, OP_CMPBR, OP_LOAD), cond encodings (COND_EQ..COND_NEVER) and flag bit indices. The comparator and the decoder use the same package.
- Natural sub-module: cond_eval, a combinational (flags[3:0], cond) -> taken function reused by the decoder's branch predictor.
- The controller itself stays one module with the FSM.

Test Plan:
- Reset: reset=1 for 2 cycles during a CMPBR -> next cycle cmp_compare=0, rsp_valid=0, req_ready=1, busy=0.
- CMPBR a=5 b=5 cond=EQ -> cmp_compare=1 for one cycle with buses 5/5 -> flags[3:0]=0001 -> rsp_valid on cycle 3 after accept, rsp_taken=1.
- CMPBR a=1 b=0 cond=LT -> flags 1010, rsp_taken=0. Then BR cond=GE on the same flags -> rsp_taken=1 with no compare strobe.
- CMPBR a=0 b=1 cond=LE -> flags 0110, taken=1. Also cond=NEVER -> taken=0 and cond=ALWAYS -> taken=1.
- LOAD a=16'h0008 -> cmp_load=1 for one cycle with bus1=0008, rsp_taken=0. Then BR cond=GT -> taken=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_taken stay stable, req_ready=0 with req_valid high. The request is accepted only in the cycle after the rsp_ready handshake.
